fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have port clk, in, 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, in, 1, an asynchronous active-low reset (0 = reset asserted).
REQ-003 The block SHALL have port pc, in, 64, the current fetch address from the PC register.
REQ-004 The block SHALL have port execute_i_is_jump, in, 1, the redirect/flush strobe from execute.
REQ-005 The block SHALL have port fetch_i_pre_pc, out, 64, the next-PC proposal fed back to the PC register.
REQ-006 The block SHALL have ports imem_req_valid (out, 1), imem_req_ready (in, 1) and imem_req_addr (out, 64), forming the instruction-memory request handshake.
REQ-007 The block SHALL have ports imem_resp_valid (in, 1) and imem_resp_data (in, 32), carrying the instruction-memory response; there is no backpressure on responses.
REQ-008 The block SHALL have ports fetch_o_valid (out, 1), fetch_o_pc (out, 64), fetch_o_instr (out, 32) and fetch_o_fault (out, 1), forming the decode-facing output register.
REQ-009 The block SHALL have port decode_i_ready, in, 1, decode's acceptance of the output register.

Function
REQ-010 The block SHALL implement an FSM with states REQ (may issue a request), WAIT (one request outstanding) and DROP (outstanding request belongs to a flushed path).
REQ-011 The block SHALL allow at most one outstanding memory request.
REQ-012 In REQ, imem_req_valid SHALL be asserted when pc[1:0]==0, !execute_i_is_jump, and (!fetch_o_valid || decode_i_ready).
REQ-013 imem_req_addr SHALL equal pc, combinationally.
REQ-014 When a request is accepted (imem_req_valid && imem_req_ready), the block SHALL latch the request PC internally, drive fetch_i_pre_pc = pc + 4 (modulo 2^64), and move to WAIT.
REQ-015 In every cycle without an accepted request, fetch_i_pre_pc SHALL equal pc, so the PC holds.
REQ-016 In WAIT, when imem_resp_valid is high and there is no jump, the block SHALL load fetch_o_pc = latched PC, fetch_o_instr = imem_resp_data, fetch_o_fault = 0, set fetch_o_valid, and return to REQ.
REQ-017 A response arriving in REQ SHALL be ignored.
REQ-018 Memory latency SHALL be unbounded; the minimum request-to-output latency is 2 cycles (accept at edge N, response in cycle N+1, output valid from edge N+2).
REQ-019 fetch_o_valid SHALL clear on a cycle where decode_i_ready is high and no new instruction is loaded.
REQ-020 When fetch_o_valid && !decode_i_ready, all fetch_o_* outputs SHALL hold stable.
REQ-021 When pc[1:0] != 0 in REQ with the output register free, the block SHALL issue no request and SHALL load fetch_o_valid = 1, fetch_o_fault = 1, fetch_o_pc = pc, fetch_o_instr = 0, remaining in REQ; no further output is produced until a jump.
REQ-022 On any cycle with execute_i_is_jump = 1, fetch_o_valid SHALL clear at the next edge, overriding any load in that cycle.
REQ-023 If execute_i_is_jump = 1 in WAIT and imem_resp_valid = 0, the next state SHALL be DROP.
REQ-024 If execute_i_is_jump = 1 in WAIT and imem_resp_valid = 1 in the same cycle, the response SHALL be discarded and the next state SHALL be REQ.
REQ-025 If execute_i_is_jump = 1 in DROP, the block SHALL stay in DROP, or go to REQ if imem_resp_valid = 1.
REQ-026 In DROP, the next response SHALL be discarded, the next state SHALL be REQ, and no request SHALL be issued while in DROP.
REQ-027 During a jump cycle, fetch_i_pre_pc SHALL equal pc; the PC register gives priority to the jump target.

Reset
REQ-028 While rst = 0, the block SHALL immediately force state = REQ, fetch_o_valid = 0, fetch_o_fault = 0, fetch_o_pc = 0, fetch_o_instr = 0 and latched PC = 0.
REQ-029 While rst = 0, imem_req_valid SHALL be 0.
REQ-030 Reset asserted mid-WAIT SHALL abandon the outstanding request, and any response arriving after reset release while in REQ SHALL be ignored.
REQ-031 The first request after reset release SHALL use the pc input value present at that time.

Verification
REQ-032 The bench SHALL cover: pc = 0x80000000, ready = 1, response 0x00000093 one cycle later, decode_i_ready = 1 -> fetch_i_pre_pc = 0x80000004 in the accept cycle; output valid with pc 0x80000000 and instr 0x00000093 two edges after accept.
REQ-033 The bench SHALL cover: decode_i_ready = 0 for 3 cycles with output valid -> outputs stable, no new request, fetch_i_pre_pc = pc; after ready rises, the next request issues in that same cycle.
REQ-034 The bench SHALL cover: jump in WAIT with no response, response arrives 2 cycles later -> state DROP, response discarded, fetch_o_valid stays 0, next request uses the jump target.
REQ-035 The bench SHALL cover: jump coincident with a response -> response discarded, next state REQ, fetch_o_valid = 0.
REQ-036 The bench SHALL cover: pc = 0x80000002 -> no imem_req_valid, fault output with fetch_o_pc 0x80000002 and instr 0; a subsequent jump clears it.
REQ-037 The bench SHALL cover: rst pulled low mid-WAIT asynchronously (between clock edges) -> outputs zero immediately; after release, a stale response is ignored and a fresh request is issued.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one aligned request at a time to instruction memory
// and holds the returned instruction, or an alignment fault, in a decode-facing register.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc,
    input  logic        execute_i_is_jump,
    output logic [63:0] fetch_i_pre_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        fetch_o_valid,
    output logic [63:0] fetch_o_pc,
    output logic [31:0] fetch_o_instr,
    output logic        fetch_o_fault,
    input  logic        decode_i_ready
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [63:0] req_pc_r;
    logic        fault_lock_r;
    logic        valid_r;
    logic [63:0] out_pc_r;
    logic [31:0] out_instr_r;
    logic        out_fault_r;

    logic        out_free_s;
    logic        aligned_s;
    logic        req_valid_s;
    logic        accept_s;
    logic [63:0] pre_pc_s;
    logic        load_resp_s;
    logic        load_fault_s;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_REQ;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; any response ends WAIT or DROP, a jump without one poisons WAIT
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_REQ: begin
                if (accept_s) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    state_next_s = ST_REQ;
                end else if (execute_i_is_jump) begin
                    state_next_s = ST_DROP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (imem_resp_valid) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_DROP;
                end
            end
            default: begin
                state_next_s = ST_REQ;
            end
        endcase
    end

    // Request handshake, PC proposal and output-register load decisions
    always_comb begin
        out_free_s   = !valid_r || decode_i_ready;
        aligned_s    = (pc[1:0] == 2'b00);
        req_valid_s  = 1'b0;
        pre_pc_s     = pc;
        load_resp_s  = 1'b0;
        load_fault_s = 1'b0;
        if (rst && (state_r == ST_REQ) && aligned_s && !execute_i_is_jump && out_free_s) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end
        accept_s = req_valid_s && imem_req_ready;
        if (accept_s) begin
            pre_pc_s = pc + 64'd4;
        end else begin
            pre_pc_s = pc;
        end
        if ((state_r == ST_WAIT) && imem_resp_valid && !execute_i_is_jump) begin
            load_resp_s = 1'b1;
        end else begin
            load_resp_s = 1'b0;
        end
        // A fault is reported once; the lock keeps the stuck PC from refaulting until a jump
        if ((state_r == ST_REQ) && !aligned_s && out_free_s && !execute_i_is_jump && !fault_lock_r) begin
            load_fault_s = 1'b1;
        end else begin
            load_fault_s = 1'b0;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc;
    assign fetch_i_pre_pc = pre_pc_s;

    // Latch the PC of the accepted request so the response can be tagged with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_pc_r <= 64'd0;
        end else if (accept_s) begin
            req_pc_r <= pc;
        end else begin
            req_pc_r <= req_pc_r;
        end
    end

    // Decode-facing output register; a jump overrides any load in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r     <= 1'b0;
            out_pc_r    <= 64'd0;
            out_instr_r <= 32'd0;
            out_fault_r <= 1'b0;
        end else if (execute_i_is_jump) begin
            valid_r     <= 1'b0;
            out_fault_r <= 1'b0;
        end else if (load_resp_s) begin
            valid_r     <= 1'b1;
            out_pc_r    <= req_pc_r;
            out_instr_r <= imem_resp_data;
            out_fault_r <= 1'b0;
        end else if (load_fault_s) begin
            valid_r     <= 1'b1;
            out_pc_r    <= pc;
            out_instr_r <= 32'd0;
            out_fault_r <= 1'b1;
        end else if (decode_i_ready) begin
            valid_r     <= 1'b0;
        end else begin
            valid_r     <= valid_r;
        end
    end

    // Fault lock: set when a misalignment fault is reported, cleared by the redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_lock_r <= 1'b0;
        end else if (execute_i_is_jump) begin
            fault_lock_r <= 1'b0;
        end else if (load_fault_s) begin
            fault_lock_r <= 1'b1;
        end else begin
            fault_lock_r <= fault_lock_r;
        end
    end

    assign fetch_o_valid = valid_r;
    assign fetch_o_pc    = out_pc_r;
    assign fetch_o_instr = out_instr_r;
    assign fetch_o_fault = out_fault_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by randomized traffic,
// all compared against a transaction-level model of the fetch stage kept in the bench.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc;
    logic        execute_i_is_jump;
    logic [63:0] fetch_i_pre_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        fetch_o_valid;
    logic [63:0] fetch_o_pc;
    logic [31:0] fetch_o_instr;
    logic        fetch_o_fault;
    logic        decode_i_ready;

    fetch_stage dut (
        .clk               (clk),
        .rst               (rst),
        .pc                (pc),
        .execute_i_is_jump (execute_i_is_jump),
        .fetch_i_pre_pc    (fetch_i_pre_pc),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .fetch_o_valid     (fetch_o_valid),
        .fetch_o_pc        (fetch_o_pc),
        .fetch_o_instr     (fetch_o_instr),
        .fetch_o_fault     (fetch_o_fault),
        .decode_i_ready    (decode_i_ready)
    );

    always #5 clk = ~clk;

    // Reference model: the PC register, the in-flight request list and the decode slot
    logic [63:0] pc_reg;
    logic [63:0] inflight_q[$];
    bit          inflight_dead;
    bit          m_valid;
    bit          m_fault;
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    bit          m_locked;

    logic        last_req;
    logic [63:0] last_addr;
    logic [63:0] last_pre;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        inflight_q.delete();
        inflight_dead = 1'b0;
        m_valid  = 1'b0;
        m_fault  = 1'b0;
        m_pc     = 64'd0;
        m_instr  = 32'd0;
        m_locked = 1'b0;
    endtask

    // One clock cycle: drive inputs, check combinational outputs, clock, check the register
    task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rd, input bit dr,
                         input bit jmp, input logic [63:0] tgt);
        bit          free;
        bit          exp_req;
        bit          acc;
        bit          deliver;
        bit          fload;
        logic [63:0] exp_pre;
        pc                = pc_reg;
        imem_req_ready    = rdy;
        imem_resp_valid   = rv;
        imem_resp_data    = rd;
        decode_i_ready    = dr;
        execute_i_is_jump = jmp;
        #2;
        free    = !m_valid || dr;
        exp_req = (inflight_q.size() == 0) && (pc_reg[1:0] == 2'b00) && !jmp && free;
        acc     = exp_req && rdy;
        exp_pre = acc ? pc_reg + 64'd4 : pc_reg;
        last_req  = imem_req_valid;
        last_addr = imem_req_addr;
        last_pre  = fetch_i_pre_pc;
        check_eq("req_valid", imem_req_valid, {63'd0, exp_req});
        check_eq("req_addr", imem_req_addr, pc_reg);
        check_eq("pre_pc", fetch_i_pre_pc, exp_pre);
        deliver = (inflight_q.size() == 1) && rv && !inflight_dead && !jmp;
        fload   = (inflight_q.size() == 0) && (pc_reg[1:0] != 2'b00) && free && !jmp && !m_locked;
        @(posedge clk);
        if (jmp) begin
            m_valid = 1'b0;
            m_fault = 1'b0;
        end else if (deliver) begin
            m_valid = 1'b1;
            m_pc    = inflight_q[0];
            m_instr = rd;
            m_fault = 1'b0;
        end else if (fload) begin
            m_valid = 1'b1;
            m_pc    = pc_reg;
            m_instr = 32'd0;
            m_fault = 1'b1;
        end else if (dr) begin
            m_valid = 1'b0;
        end
        if ((inflight_q.size() == 1) && rv) begin
            void'(inflight_q.pop_front());
            inflight_dead = 1'b0;
        end else if ((inflight_q.size() == 1) && jmp) begin
            inflight_dead = 1'b1;
        end
        if (acc) begin
            inflight_q.push_back(pc_reg);
        end
        if (jmp) begin
            m_locked = 1'b0;
        end else if (fload) begin
            m_locked = 1'b1;
        end
        pc_reg = jmp ? tgt : exp_pre;
        #1;
        check_eq("o_valid", fetch_o_valid, {63'd0, m_valid});
        if (m_valid) begin
            check_eq("o_pc", fetch_o_pc, m_pc);
            check_eq("o_instr", {32'd0, fetch_o_instr}, {32'd0, m_instr});
            check_eq("o_fault", {63'd0, fetch_o_fault}, {63'd0, m_fault});
        end
    endtask

    initial begin
        logic [63:0] tgt;
        rst               = 1'b0;
        pc                = 64'd0;
        execute_i_is_jump = 1'b0;
        imem_req_ready    = 1'b0;
        imem_resp_valid   = 1'b0;
        imem_resp_data    = 32'd0;
        decode_i_ready    = 1'b0;
        pc_reg            = 64'h0000_0000_8000_0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", {63'd0, fetch_o_valid}, 64'd0);
        check_eq("rst_pc", fetch_o_pc, 64'd0);
        check_eq("rst_instr", {32'd0, fetch_o_instr}, 64'd0);
        check_eq("rst_fault", {63'd0, fetch_o_fault}, 64'd0);
        check_eq("rst_req", {63'd0, imem_req_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic fetch, two-edge latency
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        check_eq("t1_pre_pc", last_pre, 64'h0000_0000_8000_0004);
        cycle(1'b0, 1'b1, 32'h0000_0093, 1'b1, 1'b0, 64'd0);
        check_eq("t1_valid", {63'd0, fetch_o_valid}, 64'd1);
        check_eq("t1_pc", fetch_o_pc, 64'h0000_0000_8000_0000);
        check_eq("t1_instr", {32'd0, fetch_o_instr}, 64'h0000_0093);

        // Decode stall holds the output and blocks requests
        repeat (3) begin
            cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
            check_eq("stall_pre", last_pre, 64'h0000_0000_8000_0004);
            check_eq("stall_pc", fetch_o_pc, 64'h0000_0000_8000_0000);
            check_eq("stall_instr", {32'd0, fetch_o_instr}, 64'h0000_0093);
        end
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        check_eq("unstall_req", {63'd0, last_req}, 64'd1);
        cycle(1'b0, 1'b1, 32'h0010_0113, 1'b1, 1'b0, 64'd0);
        check_eq("t2_pc", fetch_o_pc, 64'h0000_0000_8000_0004);

        // Jump in WAIT without response: late response is dropped
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 64'h0000_0000_8000_1000);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        check_eq("drop_noreq", {63'd0, last_req}, 64'd0);
        cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 64'd0);
        check_eq("drop_valid", {63'd0, fetch_o_valid}, 64'd0);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        check_eq("drop_req", {63'd0, last_req}, 64'd1);
        check_eq("drop_addr", last_addr, 64'h0000_0000_8000_1000);
        cycle(1'b0, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 64'd0);

        // Jump coincident with response
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        cycle(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1, 64'h0000_0000_8000_2000);
        check_eq("jr_valid", {63'd0, fetch_o_valid}, 64'd0);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        check_eq("jr_req", {63'd0, last_req}, 64'd1);
        check_eq("jr_addr", last_addr, 64'h0000_0000_8000_2000);
        cycle(1'b0, 1'b1, 32'h0000_5678, 1'b1, 1'b0, 64'd0);

        // Misaligned PC faults once, then stays quiet until a jump
        pc_reg = 64'h0000_0000_8000_0002;
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        check_eq("mis_req", {63'd0, last_req}, 64'd0);
        check_eq("mis_fault", {63'd0, fetch_o_fault}, 64'd1);
        check_eq("mis_pc", fetch_o_pc, 64'h0000_0000_8000_0002);
        check_eq("mis_instr", {32'd0, fetch_o_instr}, 64'd0);
        repeat (2) cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        check_eq("mis_quiet", {63'd0, fetch_o_valid}, 64'd0);
        pc_reg = 64'h0000_0000_8000_0002;
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 64'h0000_0000_8000_3000);
        check_eq("mis_jump", {63'd0, fetch_o_valid}, 64'd0);

        // Asynchronous reset in WAIT, stale response afterwards
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        cycle(1'b0, 1'b1, 32'h0000_0aaa, 1'b1, 1'b0, 64'd0);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_valid", {63'd0, fetch_o_valid}, 64'd0);
        check_eq("arst_pc", fetch_o_pc, 64'd0);
        check_eq("arst_instr", {32'd0, fetch_o_instr}, 64'd0);
        check_eq("arst_req", {63'd0, imem_req_valid}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        pc_reg = 64'h0000_0000_9000_0000;
        cycle(1'b0, 1'b1, 32'h5555_5555, 1'b1, 1'b0, 64'd0);
        check_eq("stale_valid", {63'd0, fetch_o_valid}, 64'd0);
        check_eq("fresh_req", {63'd0, last_req}, 64'd1);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        cycle(1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 64'd0);
        check_eq("fresh_pc", fetch_o_pc, 64'h0000_0000_9000_0000);

        // PC wrap-around at the top of the address space
        pc_reg = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
        check_eq("wrap_pre", last_pre, 64'd0);
        cycle(1'b0, 1'b1, 32'h0000_0073, 1'b1, 1'b0, 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            tgt = 64'h0000_0000_8000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
            if ($urandom_range(0, 9) == 0) begin
                tgt = tgt + 64'd2;
            end
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 32'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, tgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
